// File: rtl/id_ex_stage_reg_if.sv
// ID->EX stage bundle: decode-side capture inputs, WB refresh port and registered EX-side outputs.
// master drives the decode/WB side, slave is the stage register itself.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [DATA_W-1:0] pc_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic [DATA_W-1:0] imm_i;
    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [9:0]        funct_i;
    logic [1:0]        alu_op_i;
    logic              alu_src_i;
    logic              reg_write_i;
    logic              mem_to_reg_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic              wb_write_i;
    logic [ADDR_W-1:0] wb_rd_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              valid_o;
    logic [DATA_W-1:0] pc_o;
    logic [DATA_W-1:0] rs1_data_o;
    logic [DATA_W-1:0] rs2_data_o;
    logic [DATA_W-1:0] imm_o;
    logic [ADDR_W-1:0] rs1_addr_o;
    logic [ADDR_W-1:0] rs2_addr_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [9:0]        funct_o;
    logic [1:0]        alu_op_o;
    logic              alu_src_o;
    logic              reg_write_o;
    logic              mem_to_reg_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output stall_i, flush_i, valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i, alu_op_i, alu_src_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
               wb_write_i, wb_rd_i, wb_data_i,
        input  valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o,
               rd_addr_o, funct_o, alu_op_o, alu_src_o, reg_write_o, mem_to_reg_o,
               mem_read_o, mem_write_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, funct_i, alu_op_i, alu_src_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i,
               wb_write_i, wb_rd_i, wb_data_i,
        output valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o,
               rd_addr_o, funct_o, alu_op_o, alu_src_o, reg_write_o, mem_to_reg_o,
               mem_read_o, mem_write_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register, 1-cycle registered latency; priority reset > flush > stall > load.
// Stall holds contents but refreshes held operands from WB; flush inserts a counted bubble.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    id_ex_stage_reg_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rs1_addr;
        logic [ADDR_W-1:0] rs2_addr;
        logic [ADDR_W-1:0] rd_addr;
        logic [9:0]        funct;
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
    } stage_t;

    stage_t           stage_q, stage_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic wb_live;
    logic rs1_load_hit, rs2_load_hit, rs1_hold_hit, rs2_hold_hit;

    // x0 is hardwired zero, so a WB to index 0 must never be forwarded.
    assign wb_live      = bus.wb_write_i && (bus.wb_rd_i != '0);
    assign rs1_load_hit = wb_live && (bus.wb_rd_i == bus.rs1_addr_i);
    assign rs2_load_hit = wb_live && (bus.wb_rd_i == bus.rs2_addr_i);
    assign rs1_hold_hit = wb_live && (bus.wb_rd_i == stage_q.rs1_addr);
    assign rs2_hold_hit = wb_live && (bus.wb_rd_i == stage_q.rs2_addr);

    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush_i) begin
            stage_d = '0;
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (bus.stall_i) begin
            if (rs1_hold_hit) stage_d.rs1_data = bus.wb_data_i;
            if (rs2_hold_hit) stage_d.rs2_data = bus.wb_data_i;
        end else begin
            stage_d.valid      = bus.valid_i;
            stage_d.pc         = bus.pc_i;
            stage_d.rs1_data   = rs1_load_hit ? bus.wb_data_i : bus.rs1_data_i;
            stage_d.rs2_data   = rs2_load_hit ? bus.wb_data_i : bus.rs2_data_i;
            stage_d.imm        = bus.imm_i;
            stage_d.rs1_addr   = bus.rs1_addr_i;
            stage_d.rs2_addr   = bus.rs2_addr_i;
            stage_d.rd_addr    = bus.rd_addr_i;
            stage_d.funct      = bus.funct_i;
            stage_d.alu_op     = bus.alu_op_i;
            stage_d.alu_src    = bus.alu_src_i;
            // Side-effecting controls are killed for an empty slot; data rides along untouched.
            stage_d.reg_write  = bus.reg_write_i  && bus.valid_i;
            stage_d.mem_to_reg = bus.mem_to_reg_i && bus.valid_i;
            stage_d.mem_read   = bus.mem_read_i   && bus.valid_i;
            stage_d.mem_write  = bus.mem_write_i  && bus.valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.valid_o      = stage_q.valid;
    assign bus.pc_o         = stage_q.pc;
    assign bus.rs1_data_o   = stage_q.rs1_data;
    assign bus.rs2_data_o   = stage_q.rs2_data;
    assign bus.imm_o        = stage_q.imm;
    assign bus.rs1_addr_o   = stage_q.rs1_addr;
    assign bus.rs2_addr_o   = stage_q.rs2_addr;
    assign bus.rd_addr_o    = stage_q.rd_addr;
    assign bus.funct_o      = stage_q.funct;
    assign bus.alu_op_o     = stage_q.alu_op;
    assign bus.alu_src_o    = stage_q.alu_src;
    assign bus.reg_write_o  = stage_q.reg_write;
    assign bus.mem_to_reg_o = stage_q.mem_to_reg;
    assign bus.mem_read_o   = stage_q.mem_read;
    assign bus.mem_write_o  = stage_q.mem_write;
    assign bus.bubble_cnt_o = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed-vector bench for id_ex_stage_reg with a 4-bit bubble counter so saturation is reachable.
module tb_id_ex_stage_reg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;
        bus.valid_i      = 1'b0;
        bus.pc_i         = '0;
        bus.rs1_data_i   = '0;
        bus.rs2_data_i   = '0;
        bus.imm_i        = '0;
        bus.rs1_addr_i   = '0;
        bus.rs2_addr_i   = '0;
        bus.rd_addr_i    = '0;
        bus.funct_i      = '0;
        bus.alu_op_i     = '0;
        bus.alu_src_i    = 1'b0;
        bus.reg_write_i  = 1'b0;
        bus.mem_to_reg_i = 1'b0;
        bus.mem_read_i   = 1'b0;
        bus.mem_write_i  = 1'b0;
        bus.wb_write_i   = 1'b0;
        bus.wb_rd_i      = '0;
        bus.wb_data_i    = '0;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        // Reset with busy inputs
        for (int i = 0; i < 2; i++) begin
            bus.valid_i     = 1'b1;
            bus.pc_i        = $urandom;
            bus.rs1_data_i  = $urandom;
            bus.rs2_data_i  = $urandom;
            bus.imm_i       = $urandom;
            bus.rs1_addr_i  = 5'($urandom);
            bus.rd_addr_i   = 5'($urandom);
            bus.reg_write_i = 1'b1;
            bus.mem_write_i = 1'b1;
            bus.flush_i     = 1'($urandom);
            bus.stall_i     = 1'($urandom);
            tick();
        end
        chk("rst_valid", 32'(bus.valid_o), 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_rs1", bus.rs1_data_o, 32'h0);
        chk("rst_imm", bus.imm_o, 32'h0);
        chk("rst_rd", 32'(bus.rd_addr_o), 32'h0);
        chk("rst_regw", 32'(bus.reg_write_o), 32'h0);
        chk("rst_memw", 32'(bus.mem_write_o), 32'h0);
        chk("rst_cnt", 32'(bus.bubble_cnt_o), 32'h0);

        rst_i = 1'b0;
        clear_inputs();
        bus.valid_i = 1'b1;
        bus.pc_i    = 32'h40;
        tick();
        chk("load_pc", bus.pc_o, 32'h40);
        chk("load_valid", 32'(bus.valid_o), 32'h1);

        // Same-cycle WB bypass on rs1, none on rs2
        bus.rs1_addr_i = 5'd5;
        bus.rs1_data_i = 32'h11;
        bus.rs2_addr_i = 5'd6;
        bus.rs2_data_i = 32'h33;
        bus.wb_write_i = 1'b1;
        bus.wb_rd_i    = 5'd5;
        bus.wb_data_i  = 32'hAA;
        tick();
        chk("byp_rs1", bus.rs1_data_o, 32'hAA);
        chk("byp_rs2", bus.rs2_data_o, 32'h33);
        chk("byp_rs1_addr", 32'(bus.rs1_addr_o), 32'd5);

        bus.rs1_addr_i = 5'd0;
        bus.rs2_addr_i = 5'd0;
        bus.wb_rd_i    = 5'd0;
        tick();
        chk("x0_no_byp", bus.rs1_data_o, 32'h11);
        chk("x0_no_byp2", bus.rs2_data_o, 32'h33);

        // Load, then hold 3 cycles with a WB refresh in cycle 2
        clear_inputs();
        bus.valid_i     = 1'b1;
        bus.pc_i        = 32'h100;
        bus.rs1_addr_i  = 5'd3;
        bus.rs1_data_i  = 32'h33;
        bus.rs2_addr_i  = 5'd7;
        bus.rs2_data_i  = 32'h22;
        bus.imm_i       = 32'h5;
        bus.rd_addr_i   = 5'd9;
        bus.reg_write_i = 1'b1;
        tick();
        chk("pre_stall_rs2", bus.rs2_data_o, 32'h22);
        bus.stall_i    = 1'b1;
        bus.pc_i       = 32'hDEAD;
        bus.rs2_data_i = 32'h99;
        bus.rd_addr_i  = 5'd1;
        tick();
        chk("stall1_rs2", bus.rs2_data_o, 32'h22);
        chk("stall1_pc", bus.pc_o, 32'h100);
        bus.wb_write_i = 1'b1;
        bus.wb_rd_i    = 5'd7;
        bus.wb_data_i  = 32'h77;
        tick();
        chk("stall2_rs2", bus.rs2_data_o, 32'h77);
        chk("stall2_rs1", bus.rs1_data_o, 32'h33);
        chk("stall2_pc", bus.pc_o, 32'h100);
        chk("stall2_rd", 32'(bus.rd_addr_o), 32'd9);
        bus.wb_write_i = 1'b0;
        tick();
        chk("stall3_rs2", bus.rs2_data_o, 32'h77);
        chk("stall3_imm", bus.imm_o, 32'h5);
        chk("stall3_cnt", 32'(bus.bubble_cnt_o), 32'h0);

        // Held rs1 and rs2 share an index: one WB write refreshes both
        clear_inputs();
        bus.valid_i     = 1'b1;
        bus.reg_write_i = 1'b1;
        bus.pc_i        = 32'h200;
        bus.rs1_addr_i  = 5'd4;
        bus.rs2_addr_i  = 5'd4;
        bus.rs1_data_i  = 32'h1;
        bus.rs2_data_i  = 32'h2;
        tick();
        bus.stall_i    = 1'b1;
        bus.wb_write_i = 1'b1;
        bus.wb_rd_i    = 5'd4;
        bus.wb_data_i  = 32'h44;
        tick();
        chk("dual_rs1", bus.rs1_data_o, 32'h44);
        chk("dual_rs2", bus.rs2_data_o, 32'h44);

        // Flush wins over stall
        bus.wb_write_i = 1'b0;
        bus.flush_i    = 1'b1;
        tick();
        chk("fl_valid", 32'(bus.valid_o), 32'h0);
        chk("fl_regw", 32'(bus.reg_write_o), 32'h0);
        chk("fl_pc", bus.pc_o, 32'h0);
        chk("fl_rs2", bus.rs2_data_o, 32'h0);
        chk("fl_cnt", 32'(bus.bubble_cnt_o), 32'h1);
        bus.flush_i = 1'b0;
        tick();
        chk("stall_after_fl_cnt", 32'(bus.bubble_cnt_o), 32'h1);
        chk("stall_after_fl_pc", bus.pc_o, 32'h0);

        // Invalid slot: controls killed, data captured
        clear_inputs();
        bus.mem_write_i  = 1'b1;
        bus.reg_write_i  = 1'b1;
        bus.mem_read_i   = 1'b1;
        bus.mem_to_reg_i = 1'b1;
        bus.alu_src_i    = 1'b1;
        bus.alu_op_i     = 2'd2;
        bus.funct_i      = 10'h3FF;
        bus.imm_i        = 32'h8;
        tick();
        chk("inv_memw", 32'(bus.mem_write_o), 32'h0);
        chk("inv_regw", 32'(bus.reg_write_o), 32'h0);
        chk("inv_memr", 32'(bus.mem_read_o), 32'h0);
        chk("inv_m2r", 32'(bus.mem_to_reg_o), 32'h0);
        chk("inv_valid", 32'(bus.valid_o), 32'h0);
        chk("inv_imm", bus.imm_o, 32'h8);
        chk("inv_alusrc", 32'(bus.alu_src_o), 32'h1);
        chk("inv_aluop", 32'(bus.alu_op_o), 32'h2);
        chk("inv_funct", 32'(bus.funct_o), 32'h3FF);

        // Counter: starts at 1, 20 flushes saturate at 15
        clear_inputs();
        bus.flush_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4) chk("cnt_mid", 32'(bus.bubble_cnt_o), 32'd6);
        end
        chk("cnt_sat", 32'(bus.bubble_cnt_o), 32'd15);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b1;
        tick();
        chk("cnt_stall", 32'(bus.bubble_cnt_o), 32'd15);
        bus.flush_i = 1'b1;
        tick();
        chk("cnt_sat2", 32'(bus.bubble_cnt_o), 32'd15);

        // Reset mid-stall/flush restarts the counter
        rst_i = 1'b1;
        tick();
        chk("rst_mid_cnt", 32'(bus.bubble_cnt_o), 32'd0);
        rst_i = 1'b0;
        bus.stall_i = 1'b0;
        tick();
        chk("cnt_restart", 32'(bus.bubble_cnt_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
